picorv32_trace_fifo: RTL and testbench

Capture buffer downstream of the picorv32_axi trace port. It accepts the 36-bit trace_valid/trace_data stream, which carries no backpressure. It buffers words in a synchronous FIFO and presents them on a valid/ready drain interface for the bench's trace dumper or checker. Words that arrive while the FIFO is full are dropped and counted.

---
 rtl/picorv32_trace_fifo.sv | 132 +++++++++++++
 tb/tb_picorv32_trace_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_trace_fifo.sv
// Capture FIFO for the picorv32 trace port: buffers the backpressure-free trace
// stream, drains it over valid/ready, and counts words dropped while full.
// Optional per-entry cycle stamps are built when PICORV32_TRACE_TSTAMP_EN is defined.
module picorv32_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 36,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       trace_valid,
  input  logic [DATA_W-1:0]          trace_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [31:0]                out_tstamp,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Handshake: the consumer takes the head entry on any rising edge where
  // out_valid && out_ready; out_data/out_tstamp stay stable while out_valid && !out_ready.
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

  state_t            state, state_next;
  logic              full;
  logic              pop, push, drop;
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_next;
  logic              head_load, head_bypass;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] mem [DEPTH];

  assign pop  = out_valid && out_ready;
  assign push = trace_valid && (!full || pop);
  assign drop = trace_valid && full && !pop;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_EMPTY;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY:   if (push) state_next = ST_PARTIAL;
      ST_PARTIAL: begin
        if (push && !pop && level == LW'(DEPTH - 1))  state_next = ST_FULL;
        else if (pop && !push && level == LW'(1))     state_next = ST_EMPTY;
      end
      ST_FULL:    if (pop && !push) state_next = ST_PARTIAL;
      default:    state_next = ST_EMPTY;
    endcase
  end

  // Output decode
  always_comb begin
    out_valid = (state != ST_EMPTY);
    full      = (state == ST_FULL);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trace_data;
  end

  // The head register reloads only when the head changes; an incoming word that
  // becomes the new head bypasses the array since it is written this same edge.
  assign rd_next     = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign head_load   = pop || (!out_valid && push);
  assign head_bypass = push && (wr_ptr == rd_next);
  assign head_data   = head_bypass ? trace_data : mem[rd_next];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        out_data <= '0;
    else if (head_load) out_data <= head_data;
  end

  // A clear in the same cycle as a drop leaves exactly that one drop recorded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_ovf) begin
      overflow   <= drop;
      drop_count <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + CNT_W'(1);
    end
  end

`ifdef PICORV32_TRACE_TSTAMP_EN
  logic [31:0] cyc_cnt;
  logic [31:0] tmem [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cyc_cnt <= '0;
    else         cyc_cnt <= cyc_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (push) tmem[wr_ptr] <= cyc_cnt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        out_tstamp <= '0;
    else if (head_load) out_tstamp <= head_bypass ? cyc_cnt : tmem[rd_next];
  end
`else
  assign out_tstamp = 32'd0;
`endif

endmodule

// File: tb/tb_picorv32_trace_fifo.sv
// Self-checking bench for picorv32_trace_fifo: directed scenarios plus random
// traffic, scored against a queue-based occupancy/drop model.
module tb_picorv32_trace_fifo;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 36;
  localparam int CNT_W  = 16;
  localparam int SAT    = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              trace_valid = 1'b0;
  logic [DATA_W-1:0] trace_data  = '0;
  logic              out_valid;
  logic              out_ready   = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       out_tstamp;
  logic [4:0]        level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic              clr_ovf     = 1'b0;

  picorv32_trace_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .trace_valid(trace_valid), .trace_data(trace_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tstamp(out_tstamp), .level(level), .overflow(overflow),
    .drop_count(drop_count), .clr_ovf(clr_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: expected words in order ({stamp, data}), occupancy, drop state
  logic [67:0] exp_q[$];
  int          mdl_level = 0;
  bit          mdl_ovf   = 0;
  int          mdl_drops = 0;
  int unsigned mdl_cyc   = 0;

  always @(posedge clk) begin
    bit m_pop, m_full, m_push, m_drop;
    logic [31:0] stamp;
    if (!resetn) begin
      mdl_level = 0; mdl_ovf = 0; mdl_drops = 0; mdl_cyc = 0;
    end else begin
      m_pop  = (mdl_level > 0) && out_ready;
      m_full = (mdl_level == DEPTH);
      m_push = trace_valid && (!m_full || m_pop);
      m_drop = trace_valid && m_full && !m_pop;
`ifdef PICORV32_TRACE_TSTAMP_EN
      stamp = mdl_cyc;
`else
      stamp = 32'd0;
`endif
      if (m_push) exp_q.push_back({stamp, trace_data});
      mdl_level = mdl_level + int'(m_push) - int'(m_pop);
      if (clr_ovf) begin
        mdl_ovf   = m_drop;
        mdl_drops = m_drop ? 1 : 0;
      end else if (m_drop) begin
        mdl_ovf = 1;
        if (mdl_drops < SAT) mdl_drops++;
      end
      mdl_cyc++;
    end
  end

  // monitor: head and status compared on the falling edge
  always @(negedge clk) begin
    if (resetn) begin
      check("out_valid", 68'(out_valid), 68'(mdl_level > 0));
      check("level", 68'(level), 68'(mdl_level));
      check("overflow", 68'(overflow), 68'(mdl_ovf));
      check("drop_count", 68'(drop_count), 68'(mdl_drops));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 68'(out_data), 68'hX);
        end else begin
          check("head", {out_tstamp, out_data}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic step(input logic tv, input logic [DATA_W-1:0] d, input logic rdy, input logic clr);
    trace_valid = tv;
    trace_data  = d;
    out_ready   = rdy;
    clr_ovf     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    trace_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    exp_q.delete();
    mdl_level = 0; mdl_ovf = 0; mdl_drops = 0; mdl_cyc = 0;
    #1;
    check("rst_out_valid", 68'(out_valid), 68'd0);
    check("rst_level", 68'(level), 68'd0);
    check("rst_out_data", 68'(out_data), 68'd0);
    check("rst_overflow", 68'(overflow), 68'd0);
    check("rst_drop_count", 68'(drop_count), 68'd0);
    @(posedge clk); @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

`ifdef PICORV32_TRACE_TSTAMP_EN
  localparam logic [31:0] STAMP_A = 32'd10;
  localparam logic [31:0] STAMP_B = 32'd13;
`else
  localparam logic [31:0] STAMP_A = 32'd0;
  localparam logic [31:0] STAMP_B = 32'd0;
`endif

  initial begin
    @(posedge clk); #1;
    do_reset();

    // basic order
    step(1, 36'h1, 1, 0);
    check("t1_latency", 68'(out_valid), 68'd1);
    check("t1_first", 68'(out_data), 68'h1);
    step(1, 36'h2, 1, 0);
    step(1, 36'h3, 1, 0);
    repeat (3) step(0, '0, 1, 0);
    check("t1_level", 68'(level), 68'd0);
    check("t1_overflow", 68'(overflow), 68'd0);

    // fill and overflow
    do_reset();
    for (int i = 0; i < 20; i++) step(1, DATA_W'(i), 0, 0);
    check("t2_level", 68'(level), 68'd16);
    check("t2_overflow", 68'(overflow), 68'd1);
    check("t2_drops", 68'(drop_count), 68'd4);
    repeat (18) step(0, '0, 1, 0);
    check("t2_drained", 68'(level), 68'd0);

    // full with simultaneous push/pop
    do_reset();
    for (int i = 0; i < 16; i++) step(1, DATA_W'(i + 100), 0, 0);
    step(1, 36'hABC, 1, 0);
    check("t3_level", 68'(level), 68'd16);
    check("t3_drops", 68'(drop_count), 68'd0);
    repeat (18) step(0, '0, 1, 0);

    // clear vs drop
    do_reset();
    for (int i = 0; i < 20; i++) step(1, DATA_W'(i), 0, 0);
    step(1, 36'd99, 0, 1);
    check("t4_ovf_after_clr_drop", 68'(overflow), 68'd1);
    check("t4_cnt_after_clr_drop", 68'(drop_count), 68'd1);
    step(0, '0, 0, 1);
    check("t4_ovf_cleared", 68'(overflow), 68'd0);
    check("t4_cnt_cleared", 68'(drop_count), 68'd0);
    repeat (18) step(0, '0, 1, 0);

    // backpressure hold, then reset mid-stream
    do_reset();
    step(1, 36'h5A5, 0, 0);
    step(1, 36'h5A6, 0, 0);
    step(1, 36'h5A7, 0, 0);
    repeat (5) step(0, '0, 0, 0);
    check("t5_hold", 68'(out_data), 68'h5A5);
    resetn = 1'b0;
    #1;
    check("t5_async_valid", 68'(out_valid), 68'd0);
    check("t5_async_level", 68'(level), 68'd0);
    do_reset();
    step(1, 36'h77, 0, 0);
    check("t5_post_rst_valid", 68'(out_valid), 68'd1);
    check("t5_post_rst_data", 68'(out_data), 68'h77);
    repeat (2) step(0, '0, 1, 0);

    // cycle stamps: first edge after release is cycle 0
    do_reset();
    repeat (10) step(0, '0, 0, 0);
    step(1, 36'hA, 0, 0);
    check("t6_stamp_a", 68'(out_tstamp), 68'(STAMP_A));
    repeat (2) step(0, '0, 0, 0);
    step(1, 36'hB, 1, 0);
    check("t6_stamp_b", 68'(out_tstamp), 68'(STAMP_B));
    repeat (2) step(0, '0, 1, 0);

    // random traffic with bursts of backpressure
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit rdy;
      rdy = ((i / 100) % 3 == 1) ? ($urandom_range(9) == 0) : ($urandom_range(1) == 1);
      step($urandom_range(9) < 7, {4'($urandom_range(15)), 32'($urandom)}, rdy,
           $urandom_range(49) == 0);
    end
    repeat (20) step(0, '0, 1, 0);
    check("final_empty", 68'(exp_q.size()), 68'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
